addsub_accumulator: RTL
=======================

Name: addsub_accumulator

Overview:
- Downstream consumer of the multi-bit adder/subtractor result.
- Accepts a stream of signed (DATAW+1)-bit results over a valid/ready handshake and sums NUM_ITEMS of them into a wider accumulator.
- Presents the batch total with its own valid/ready handshake, then starts the next batch.
- Runs on one clock; reset is synchronous and active-high.

Parameters:
- DATAW, 2, operand width of the upstream adder/subtractor; input result width is DATAW+1.
- ACCW, 16, accumulator and output width; must be >= DATAW+1.
- NUM_ITEMS, 4, results per batch; must be >= 1.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- i_valid  input  1  upstream result valid.
- o_ready  output  1  block can accept a result this cycle.
- i_result  input  DATAW+1  upstream result, two's-complement signed.
- i_clear  input  1  abort the current batch.
- o_valid  output  1  batch sum valid.
- i_ready  input  1  downstream accepts the sum.
- o_sum  output  ACCW  accumulator value, signed.
- o_overflow  output  1  sticky signed-overflow flag for the current batch.

Behaviour:
- Reset (rst=1 at an edge):
  - state=ACCUM, accumulator=0, item count=0, o_valid=0, o_overflow=0, o_sum=0.
  - Reset mid-batch or mid-DONE discards everything.
- States: ACCUM, DONE.
- o_ready is combinational: 1 iff state==ACCUM and i_clear==0.
- Beat acceptance: a beat is accepted when i_valid && o_ready.
  - On acceptance: acc <= acc + sign_extend(i_result) to ACCW bits, and count++.
- ACCUM -> DONE: when a beat is accepted with count==NUM_ITEMS-1.
  - o_valid rises the cycle after the final beat, with o_sum equal to the full total.
  - Latency from final beat to o_valid is one cycle.
- DONE:
  - o_ready=0; i_valid, i_result and i_clear are ignored.
  - o_valid, o_sum and o_overflow are held stable until i_ready=1.
- DONE -> ACCUM: on o_valid && i_ready.
  - Next cycle: o_valid=0, acc=0, count=0, o_overflow=0.
  - A new beat can be accepted in that same next cycle.
- o_sum always shows the accumulator register; it is meaningful only while o_valid=1.
- i_clear (ACCUM only):
  - Next cycle: acc=0, count=0, o_overflow=0.
  - A simultaneous i_valid beat is not accepted, because o_ready is already low.
- Overflow:
  - Signed overflow occurs when the operand signs match and the result sign differs.
  - Default behaviour: the accumulator wraps modulo 2^ACCW.
  - o_overflow is set on the cycle after the overflowing add and stays high until batch handshake, i_clear or rst.
- NUM_ITEMS=1: every accepted beat goes straight to DONE.

Optional Feature:
- Macro: ADDSUB_ACC_SATURATE_EN.
- Defined: an overflowing add clamps the accumulator to 2^(ACCW-1)-1 (positive overflow) or -2^(ACCW-1) (negative overflow).
  - o_overflow is still set and is sticky as above.
  - Later adds start from the clamped value.
- Undefined: wrap-around, as in Behaviour.

Test Plan:
All cases use DATAW=2, NUM_ITEMS=4 and i_ready=1 unless stated otherwise.
- ACCW=8, beats 3,3,2,1 back-to-back -> o_valid=1 exactly one cycle after the 4th beat, o_sum=0x09, o_overflow=0; o_valid=0 the following cycle.
- ACCW=8, beats -4,-4,-4,-4 -> o_sum=0xF0 (-16), o_overflow=0.
- ACCW=8, batch 1,1,1,1 with i_ready held low 5 cycles after o_valid, i_valid held high throughout -> o_ready=0 and o_sum=0x04 stable for 5 cycles; no beats are consumed; the next batch starts the cycle after i_ready=1 and its 4 beats of 2 give 0x08.
- ACCW=8, beats 3,3, then i_clear=1 together with i_valid=1 (value 3) -> that beat is not accepted; next beats 1,1,1,1 -> o_sum=0x04.
- ACCW=4, beats 3,3,3,3:
  - Without macro: o_sum=0xC (-4), o_overflow=1.
  - With ADDSUB_ACC_SATURATE_EN: o_sum=0x7, o_overflow=1.
  - o_overflow=0 after the handshake.
- ACCW=8, beats 2,2 then rst=1 for one cycle, then beats 1,1,1,1 -> outputs read zero right after reset; final o_sum=0x04.

Source files
------------

// File: rtl/addsub_accumulator.sv
// Batch accumulator for signed adder/subtractor results: sums NUM_ITEMS beats, then offers the total.
// Define ADDSUB_ACC_SATURATE_EN to clamp on signed overflow instead of wrapping.
module addsub_accumulator #(
  parameter int DATAW     = 2,
  parameter int ACCW      = 16,
  parameter int NUM_ITEMS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [DATAW:0]   i_result,
  input  logic             i_clear,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [ACCW-1:0]  o_sum,
  output logic             o_overflow
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds valid and data stable until that edge, and ready never
  // depends on this block's own valid output.

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

  localparam int CNTW = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NUM_ITEMS - 1);

  state_t            state_q, state_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic [ACCW-1:0]   addend;
  logic [ACCW-1:0]   raw_sum;
  logic [ACCW-1:0]   add_res;
  logic              add_ovf;
  logic              take;

  assign addend  = ACCW'($signed(i_result));
  assign raw_sum = acc_q + addend;
  // Overflow: operands agree in sign but the sum does not.
  assign add_ovf = (acc_q[ACCW-1] == addend[ACCW-1]) &&
                   (raw_sum[ACCW-1] != acc_q[ACCW-1]);

`ifdef ADDSUB_ACC_SATURATE_EN
  always_comb begin
    add_res = raw_sum;
    if (add_ovf) begin
      add_res = acc_q[ACCW-1] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
    end
  end
`else
  assign add_res = raw_sum;
`endif

  assign o_ready    = (state_q == ACCUM) && !i_clear;
  assign take       = i_valid && o_ready;
  assign o_valid    = (state_q == DONE);
  assign o_sum      = acc_q;
  assign o_overflow = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (i_clear) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (take) begin
          acc_d = add_res;
          ovf_d = ovf_q | add_ovf;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (i_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
